// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to packed BCD converter (shift-add-3, one bit/clk).
// Holds the last result for the 7-segment display driver between conversions.
module bin2bcd_seq #(
    parameter int WIDTH = 32,
    parameter int DIGITS = 8,
    parameter logic [4*DIGITS-1:0] ERR_CODE = 32'hEEEE_EEEE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  auto_en,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [63:0] max_dec(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAXV = max_dec(DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0]    shreg;
    logic [BW-1:0]       acc;
    logic [BW-1:0]       acc_adj;
    logic [BW+WIDTH-1:0] shifted;
    logic [CW-1:0]       cnt;
    logic                ovf_nx;
    logic                auto_pending;
    logic                go;

    assign go = start | auto_pending;

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {acc_adj, shreg} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (go) state_nx = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg        <= '0;
            acc          <= '0;
            cnt          <= '0;
            ovf_nx       <= 1'b0;
            auto_pending <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ovf          <= 1'b0;
            bcd          <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        shreg        <= bin;
                        acc          <= '0;
                        cnt          <= CW'(WIDTH);
                        ovf_nx       <= 64'(bin) > MAXV;
                        busy         <= 1'b1;
                        auto_pending <= 1'b0;
                    end
                end
                SHIFT: begin
                    acc   <= shifted[BW+WIDTH-1 -: BW];
                    shreg <= shifted[WIDTH-1:0];
                    cnt   <= cnt - CW'(1);
                end
                DONE: begin
                    // Out-of-range inputs lose their top bits in acc; show ERR_CODE instead.
                    bcd          <= ovf_nx ? ERR_CODE : acc;
                    ovf          <= ovf_nx;
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    auto_pending <= auto_en;
                end
                default: ;
            endcase
        end
    end

endmodule
